// File: rtl/param_sync_counter_if.sv
// Control and status bundle of the modulo counter.
// master drives the controls, slave is the counter.
interface param_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val,
    input  count, tc, wrap, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, tc, wrap, ovf
  );
endinterface

// File: rtl/param_sync_counter.sv
// Synchronous modulo up/down counter with prescaler,
// clear/load, wrap or saturate, tc/wrap/ovf flags.
module param_sync_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = 0,
  parameter int     PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  param_sync_counter_if.slave bus
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0] PLAST =
    PW'(PRESCALE - 1);
  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] ld_val;
  logic [PW-1:0]    presc_q;
  logic             wrap_q;
  logic             ovf_q;
  logic             tc;
  logic             tick;

  // terminal count depends on the live direction
  assign tc   = bus.up ? (cnt_q == MAX)
                       : (cnt_q == '0);
  assign tick = bus.en && (presc_q == PLAST);

  // out-of-range load values clamp to the top state
  assign ld_val = (bus.load_val > MAX) ? MAX
                                       : bus.load_val;

  // step value for a tick, modulo MODULUS
  always_comb begin
    cnt_nxt = cnt_q;
    unique case (1'b1)
      bus.up && !tc:  cnt_nxt = cnt_q + 1'b1;
      bus.up && tc:   cnt_nxt = SAT ? cnt_q : '0;
      !bus.up && !tc: cnt_nxt = cnt_q - 1'b1;
      default:        cnt_nxt = SAT ? cnt_q : MAX;
    endcase
  end

  // prescaler: counts enabled cycles, restarts on
  // tick, clear or load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (bus.clr || bus.load || tick) begin
      presc_q <= '0;
    end else if (bus.en) begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // count register: clear > load > tick > hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clr) begin
      cnt_q <= '0;
    end else if (bus.load) begin
      cnt_q <= ld_val;
    end else if (tick) begin
      cnt_q <= cnt_nxt;
    end
  end

  // wrap pulses for one cycle per boundary tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= !bus.clr && !bus.load && tick && tc;
    end
  end

  // ovf is sticky until clear or reset; load keeps it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.clr) begin
      ovf_q <= 1'b0;
    end else if (!bus.load && tick && tc) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.count = cnt_q;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_param_sync_counter.sv
// Bench for param_sync_counter: four configurations
// driven in parallel, checked against a plain model.
module tb_param_sync_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  int total = 0;
  int bad = 0;

  int MODS[4] = '{16, 10, 10, 16};
  int SATS[4] = '{0, 0, 1, 0};
  int PRES[4] = '{1, 1, 1, 3};

  int mc[4];
  int mp[4];
  bit mw[4];
  bit mo[4];

  logic [3:0] cnt[4];
  logic       tcv[4];
  logic       wr[4];
  logic       ov[4];

  always #5 clk = ~clk;

  param_sync_counter_if #(.WIDTH(4)) b0 ();
  param_sync_counter_if #(.WIDTH(4)) b1 ();
  param_sync_counter_if #(.WIDTH(4)) b2 ();
  param_sync_counter_if #(.WIDTH(4)) b3 ();

  assign b0.en = en;
  assign b0.up = up;
  assign b0.clr = clr;
  assign b0.load = load;
  assign b0.load_val = load_val;
  assign b1.en = en;
  assign b1.up = up;
  assign b1.clr = clr;
  assign b1.load = load;
  assign b1.load_val = load_val;
  assign b2.en = en;
  assign b2.up = up;
  assign b2.clr = clr;
  assign b2.load = load;
  assign b2.load_val = load_val;
  assign b3.en = en;
  assign b3.up = up;
  assign b3.clr = clr;
  assign b3.load = load;
  assign b3.load_val = load_val;

  assign cnt[0] = b0.count;
  assign cnt[1] = b1.count;
  assign cnt[2] = b2.count;
  assign cnt[3] = b3.count;
  assign tcv[0] = b0.tc;
  assign tcv[1] = b1.tc;
  assign tcv[2] = b2.tc;
  assign tcv[3] = b3.tc;
  assign wr[0] = b0.wrap;
  assign wr[1] = b1.wrap;
  assign wr[2] = b2.wrap;
  assign wr[3] = b3.wrap;
  assign ov[0] = b0.ovf;
  assign ov[1] = b1.ovf;
  assign ov[2] = b2.ovf;
  assign ov[3] = b3.ovf;

  param_sync_counter #(
    .WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  param_sync_counter #(
    .WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  param_sync_counter #(
    .WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)
  ) u2 (.clk(clk), .rst(rst), .bus(b2));

  param_sync_counter #(
    .WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(3)
  ) u3 (.clk(clk), .rst(rst), .bus(b3));

  // reference: modulo arithmetic on integers
  always @(posedge clk or posedge rst) begin
    int c, p, m;
    bit w, o, bnd;
    for (int i = 0; i < 4; i++) begin
      m = MODS[i];
      c = mc[i];
      p = mp[i];
      o = mo[i];
      w = 1'b0;
      if (rst || clr) begin
        c = 0;
        p = 0;
        o = 1'b0;
      end else if (load) begin
        c = (int'(load_val) >= m) ? m - 1
                                  : int'(load_val);
        p = 0;
      end else if (en) begin
        p = p + 1;
        if (p == PRES[i]) begin
          p = 0;
          bnd = up ? (c == m - 1) : (c == 0);
          if (bnd) begin
            w = 1'b1;
            o = 1'b1;
          end
          if (!(bnd && SATS[i] != 0))
            c = (c + (up ? 1 : m - 1)) % m;
        end
      end
      mc[i] <= c;
      mp[i] <= p;
      mw[i] <= w;
      mo[i] <= o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en = 1'b0;
    up = 1'b1;
    clr = 1'b0;
    load = 1'b0;
    load_val = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    en = 1'b1;
    up = 1'b1;
    repeat (9) step();
    total++;
    if (cnt[0] !== 4'd9) begin
      bad++;
      $display("FAIL reset_pre count=%0d want 9",
               cnt[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (cnt[0] !== 4'd0 || wr[0] !== 1'b0 ||
        ov[0] !== 1'b0 || tcv[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_async c=%0d w=%b o=%b t=%b want 0000",
               cnt[0], wr[0], ov[0], tcv[0]);
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (cnt[0] !== 4'(k)) begin
        bad++;
        $display("FAIL reset_resume count=%0d want %0d",
                 cnt[0], k);
      end
    end
  endtask

  task automatic test_bcd_wrap();
    int e;
    apply_reset();
    en = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      e = k % 10;
      total++;
      if (cnt[1] !== 4'(e) || tcv[1] !== (e == 9) ||
          wr[1] !== (k == 10) ||
          ov[1] !== (k >= 10)) begin
        bad++;
        $display("FAIL bcd k=%0d c=%0d t=%b w=%b o=%b want c=%0d t=%b w=%b o=%b",
                 k, cnt[1], tcv[1], wr[1], ov[1],
                 e, e == 9, k == 10, k >= 10);
      end
    end
  endtask

  task automatic test_down_saturate();
    int e;
    apply_reset();
    load = 1'b1;
    load_val = 4'd2;
    step();
    load = 1'b0;
    up = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      e = (k < 2) ? 2 - k : 0;
      total++;
      if (cnt[2] !== 4'(e) || wr[2] !== (k >= 3) ||
          ov[2] !== (k >= 3)) begin
        bad++;
        $display("FAIL sat k=%0d c=%0d w=%b o=%b want c=%0d w=%b o=%b",
                 k, cnt[2], wr[2], ov[2],
                 e, k >= 3, k >= 3);
      end
    end
  endtask

  task automatic test_prescaler();
    bit pat[5] = '{1, 0, 1, 0, 1};
    apply_reset();
    en = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      total++;
      if (cnt[3] !== 4'(k / 3)) begin
        bad++;
        $display("FAIL presc k=%0d count=%0d want %0d",
                 k, cnt[3], k / 3);
      end
    end
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      en = pat[k];
      step();
      total++;
      if (cnt[3] !== ((k == 4) ? 4'd1 : 4'd0)) begin
        bad++;
        $display("FAIL presc_gap k=%0d count=%0d want %0d",
                 k, cnt[3], k == 4);
      end
    end
  endtask

  task automatic test_load_priority();
    apply_reset();
    load = 1'b1;
    load_val = 4'd13;
    step();
    total++;
    if (cnt[1] !== 4'd9) begin
      bad++;
      $display("FAIL load_clamp count=%0d want 9",
               cnt[1]);
    end
    load = 1'b0;
    en = 1'b1;
    up = 1'b1;
    step();
    total++;
    if (cnt[1] !== 4'd0 || wr[1] !== 1'b1 ||
        ov[1] !== 1'b1) begin
      bad++;
      $display("FAIL load_wrap c=%0d w=%b o=%b want 0 1 1",
               cnt[1], wr[1], ov[1]);
    end
    en = 1'b0;
    clr = 1'b1;
    load = 1'b1;
    load_val = 4'd5;
    step();
    total++;
    if (cnt[1] !== 4'd0 || ov[1] !== 1'b0 ||
        wr[1] !== 1'b0) begin
      bad++;
      $display("FAIL clr_load c=%0d o=%b w=%b want 0 0 0",
               cnt[1], ov[1], wr[1]);
    end
    clr = 1'b0;
    load_val = 4'd9;
    step();
    en = 1'b1;
    load_val = 4'd4;
    step();
    total++;
    if (cnt[1] !== 4'd4 || wr[1] !== 1'b0 ||
        ov[1] !== 1'b0) begin
      bad++;
      $display("FAIL load_tick c=%0d w=%b o=%b want 4 0 0",
               cnt[1], wr[1], ov[1]);
    end
    load = 1'b0;
  endtask

  task automatic test_direction();
    apply_reset();
    load = 1'b1;
    load_val = 4'd5;
    step();
    load = 1'b0;
    en = 1'b1;
    up = 1'b1;
    step();
    total++;
    if (cnt[0] !== 4'd6) begin
      bad++;
      $display("FAIL dir_up count=%0d want 6", cnt[0]);
    end
    up = 1'b0;
    step();
    total++;
    if (cnt[0] !== 4'd5) begin
      bad++;
      $display("FAIL dir_down count=%0d want 5",
               cnt[0]);
    end
    en = 1'b0;
    load = 1'b1;
    load_val = 4'd0;
    step();
    load = 1'b0;
    up = 1'b0;
    #1;
    total++;
    if (tcv[0] !== 1'b1) begin
      bad++;
      $display("FAIL tc_down tc=%b want 1", tcv[0]);
    end
    up = 1'b1;
    #1;
    total++;
    if (tcv[0] !== 1'b0) begin
      bad++;
      $display("FAIL tc_up tc=%b want 0", tcv[0]);
    end
  endtask

  task automatic test_random();
    bit et;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 3) != 0);
      up = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      step();
      for (int i = 0; i < 4; i++) begin
        et = up ? (mc[i] == MODS[i] - 1)
                : (mc[i] == 0);
        total++;
        if (cnt[i] !== 4'(mc[i]) || tcv[i] !== et ||
            wr[i] !== mw[i] || ov[i] !== mo[i]) begin
          bad++;
          $display("FAIL rand n=%0d u=%0d c=%0d t=%b w=%b o=%b want c=%0d t=%b w=%b o=%b",
                   n, i, cnt[i], tcv[i], wr[i], ov[i],
                   mc[i], et, mw[i], mo[i]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bcd_wrap();
    test_down_saturate();
    test_prescaler();
    test_load_priority();
    test_direction();
    test_random();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_counter.md
Name: param_sync_counter

Overview:
- Fully synchronous, parametrised modulo up/down counter; successor to the 4-bit ripple counter.
- Adds configurable width and modulus, count direction, enable with prescaler, synchronous clear and parallel load, wrap or saturate mode, terminal-count/boundary flags and a sticky overflow flag.
- Used as the general-purpose counter/timer primitive in lab designs: event counters, BCD digits, timebase dividers.

Parameters:
- WIDTH, 4, bit width of count; 1..32.
- MODULUS, 16, number of states; count range 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH.
- SATURATE, 0, 0 = wrap at boundary, 1 = hold at boundary.
- PRESCALE, 1, enabled cycles per count step; 1..256; 1 = step every enabled cycle.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, count enable; feeds the prescaler.
- up, input, 1, direction: 1 = increment, 0 = decrement; sampled at each tick.
- clr, input, 1, synchronous clear.
- load, input, 1, synchronous parallel load.
- load_val, input, WIDTH, load value.
- count, output, WIDTH, registered count value.
- tc, output, 1, combinational terminal count: (up && count==MODULUS-1) || (!up && count==0).
- wrap, output, 1, registered one-cycle pulse on a boundary event.
- ovf, output, 1, registered sticky boundary flag.

Behaviour:
- Reset (rst=1, asynchronous, immediate, any time including mid-count): count=0, prescaler=0, wrap=0, ovf=0. tc follows count and up, so tc = !up while in reset.
- tick is internal: tick = en && (presc == PRESCALE-1).
  - presc increments on each en=1 cycle.
  - presc returns to 0 on tick, clr or load.
  - presc holds when en=0.
  - PRESCALE=1 gives tick = en.
- Priority per clock edge is clr > load > tick > hold.
- clr: count<=0, presc<=0, wrap<=0, ovf<=0. Applies regardless of en.
- load: count<=load_val if load_val<MODULUS, else count<=MODULUS-1 (clamped). presc<=0, wrap<=0, ovf unchanged.
- Tick, up=1:
  - count<MODULUS-1: count+1.
  - count==MODULUS-1 (boundary): SATURATE=0 gives count<=0; SATURATE=1 gives count held.
- Tick, up=0:
  - count>0: count-1.
  - count==0 (boundary): SATURATE=0 gives count<=MODULUS-1; SATURATE=1 gives count held.
- Boundary event (a tick while tc=1, either mode): wrap<=1 for exactly one cycle and ovf<=1.
  - ovf stays high until clr or rst.
  - wrap<=0 on every other edge.
- Latency: count, wrap and ovf update at the clock edge following the qualifying inputs. tc is valid in the same cycle as count.
- A direction change between ticks takes effect on the next tick. No glitch on count; all count bits change on the same edge.
- Simultaneous events:
  - clr+load: clear wins.
  - load+tick: load wins; no wrap pulse; prescaler restarts.
- Consecutive boundary ticks in saturate mode produce one wrap pulse per tick.
- Arithmetic is modulo MODULUS, never 2^WIDTH. With a non-power-of-two MODULUS, count never leaves 0..MODULUS-1.

Test Plan:
- Reset: WIDTH=4, MODULUS=16, PRESCALE=1. Assert rst mid-count at count=9, between clock edges -> count=0, wrap=0, ovf=0 immediately, before the next edge. Release rst, en=1, up=1 -> count 1,2,3 on successive edges.
- BCD wrap: MODULUS=10, en=1, up=1, 12 edges -> count 1..9,0,1,2. tc high while count=9. wrap high exactly one cycle, coincident with count=0. ovf=1 thereafter.
- Down and saturate: SATURATE=1, MODULUS=10, load load_val=2, then up=0, en=1, 5 edges -> count 1,0,0,0,0. wrap pulses on the 3rd, 4th and 5th edges. ovf=1.
- Prescaler: PRESCALE=3, en=1 for 9 cycles -> count steps 0->1->2->3 on cycles 3, 6, 9. With en toggled 1,0,1,0,1 -> one step after the third en=1 cycle.
- Load clamp and priority: MODULUS=10, load_val=13 -> count=9. clr+load same edge -> count=0, ovf=0. load+tick at the boundary -> count=load_val, wrap=0.
- Direction change: count=5, tick with up=1 then tick with up=0 -> 6 then 5. tc toggles with up in the same cycle at count=0 (up=0 -> tc=1; up=1 -> tc=0).
